// File: rtl/flash_sample_reader.sv
// rtl/flash_sample_reader.sv - Avalon-MM flash word reader that splits words into a 16-bit sample stream
// Optional continuous playback: define FLASH_READER_LOOP_EN.
module flash_sample_reader #(
  parameter logic [22:0] START_ADDR = 23'h000000,
  parameter logic [22:0] END_ADDR   = 23'h1FFFFF,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  output logic        flash_mem_read,
  output logic [22:0] flash_mem_address,
  output logic [3:0]  flash_mem_byteenable,
  output logic        flash_mem_burstcount,
  input  logic        flash_mem_waitrequest,
  input  logic [31:0] flash_mem_readdata,
  input  logic        flash_mem_readdatavalid,
  output logic [15:0] sample_data,
  output logic        sample_valid,
  input  logic        sample_ready,
  output logic        busy,
  output logic        done
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_REQ, S_WAIT, S_PUSH_LO, S_PUSH_HI, S_END
  } state_t;

  state_t        state, state_nxt;
  logic [22:0]   addr;
  logic [31:0]   rd_word;
  logic [15:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          fifo_wr, fifo_pop, has_space;
  logic [15:0]   fifo_wdata;

  // Each word produces two samples, so a request is only issued with two free slots.
  assign has_space = (CW'(FIFO_DEPTH) - count) >= CW'(2);
  assign fifo_pop  = sample_valid && sample_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = S_CHECK;
      S_CHECK:   if (has_space) state_nxt = S_REQ;
      S_REQ:     if (!flash_mem_waitrequest) state_nxt = S_WAIT;
      S_WAIT:    if (flash_mem_readdatavalid) state_nxt = S_PUSH_LO;
      S_PUSH_LO: state_nxt = S_PUSH_HI;
      S_PUSH_HI: state_nxt = (addr == END_ADDR) ? S_END : S_CHECK;
`ifdef FLASH_READER_LOOP_EN
      S_END:     state_nxt = S_CHECK;
`else
      S_END:     state_nxt = S_IDLE;
`endif
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    flash_mem_read = (state == S_REQ);
    busy           = (state != S_IDLE);
    done           = (state == S_END);
    fifo_wr        = (state == S_PUSH_LO) || (state == S_PUSH_HI);
    fifo_wdata     = (state == S_PUSH_HI) ? rd_word[31:16] : rd_word[15:0];
  end

  assign flash_mem_address    = addr;
  assign flash_mem_byteenable = 4'b1111;
  assign flash_mem_burstcount = 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr    <= START_ADDR;
      rd_word <= '0;
    end else begin
      if (state == S_WAIT && flash_mem_readdatavalid) rd_word <= flash_mem_readdata;
      if (state == S_PUSH_HI && addr != END_ADDR) addr <= addr + 23'd1;
      if (state == S_END) addr <= START_ADDR;
    end
  end

  // First-word-fall-through sample FIFO; pointers wrap naturally at a power-of-2 depth.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
    end else begin
      if (fifo_wr) begin
        fifo_mem[wr_ptr] <= fifo_wdata;
        wr_ptr           <= wr_ptr + PW'(1);
      end
      if (fifo_pop) rd_ptr <= rd_ptr + PW'(1);
      case ({fifo_wr, fifo_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign sample_valid = (count != '0);
  assign sample_data  = sample_valid ? fifo_mem[rd_ptr] : 16'h0000;

endmodule
